// File: rtl/polaris_bus_pkg.sv
// Shared types and constants for the Polaris I/D bus arbiter.
package polaris_bus_pkg;

    localparam int unsigned DW  = 64;
    localparam int unsigned IDW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // Read data returned to a master whose transfer timed out.
    localparam logic [DW-1:0] BUS_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/polaris_bus_arbiter_if.sv
// I-master, D-master and shared-bus signals of the Polaris bus arbiter.
interface polaris_bus_arbiter_if #(
    parameter int unsigned AW = 64
);
    logic [AW-1:0] iadr_i;
    logic [1:0]    isiz_i;
    logic          iack_o;
    logic [31:0]   idat_o;

    logic          dcyc_i;
    logic          dstb_i;
    logic          dwe_i;
    logic [AW-1:0] dadr_i;
    logic [63:0]   ddat_i;
    logic [1:0]    dsiz_i;
    logic          dsigned_i;
    logic          dack_o;
    logic [63:0]   ddat_o;

    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [63:0]   dat_o;
    logic [1:0]    siz_o;
    logic          signed_o;
    logic          ack_i;
    logic [63:0]   dat_i;

    logic [1:0]    gnt_o;
    logic          berr_o;

    // Arbiter side.
    modport slave (
        input  iadr_i, isiz_i, dcyc_i, dstb_i, dwe_i, dadr_i, ddat_i, dsiz_i, dsigned_i,
        input  ack_i, dat_i,
        output iack_o, idat_o, dack_o, ddat_o,
        output cyc_o, stb_o, we_o, adr_o, dat_o, siz_o, signed_o, gnt_o, berr_o
    );

    // CPU masters plus interconnect side.
    modport master (
        output iadr_i, isiz_i, dcyc_i, dstb_i, dwe_i, dadr_i, ddat_i, dsiz_i, dsigned_i,
        output ack_i, dat_i,
        input  iack_o, idat_o, dack_o, ddat_o,
        input  cyc_o, stb_o, we_o, adr_o, dat_o, siz_o, signed_o, gnt_o, berr_o
    );

endinterface

// File: rtl/polaris_bus_timeout.sv
// Grant-duration counter; expire_c flags the terminal cycle of a stalled grant.
module polaris_bus_timeout #(
    parameter int unsigned TMO_W = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TMO_W'(1);
        end
    end

    assign expire_c = en & (cnt_q == {TMO_W{1'b1}});

endmodule

// File: rtl/polaris_bus_arbiter.sv
// Alternating-priority arbiter sharing one 64-bit bus between the I and D masters.
// Optional grant timeout with error response: define POLARIS_BUS_TIMEOUT_EN.
module polaris_bus_arbiter
    import polaris_bus_pkg::*;
#(
    parameter int unsigned AW = 64
`ifdef POLARIS_BUS_TIMEOUT_EN
    ,
    parameter int unsigned TMO_W = 8
`endif
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    polaris_bus_arbiter_if.slave  bus
);

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;   // 1: last completed grant went to D
    logic   ireq, dreq;

    assign ireq = (bus.isiz_i != 2'b00);
    assign dreq = bus.dcyc_i & bus.dstb_i;

`ifdef POLARIS_BUS_TIMEOUT_EN
    logic tmo_clr, tmo_en, tmo_expire_c;

    polaris_bus_timeout #(.TMO_W(TMO_W)) u_timeout (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .expire_c (tmo_expire_c)
    );
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Arbitration, bus mux and ack/data return.
    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        bus.gnt_o    = GNT_NONE;
        bus.cyc_o    = 1'b0;
        bus.stb_o    = 1'b0;
        bus.we_o     = 1'b0;
        bus.adr_o    = AW'(0);
        bus.dat_o    = DW'(0);
        bus.siz_o    = 2'b00;
        bus.signed_o = 1'b0;
        bus.iack_o   = 1'b0;
        bus.idat_o   = IDW'(0);
        bus.dack_o   = 1'b0;
        bus.ddat_o   = DW'(0);
        bus.berr_o   = 1'b0;
`ifdef POLARIS_BUS_TIMEOUT_EN
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef POLARIS_BUS_TIMEOUT_EN
                tmo_clr = 1'b1;
`endif
                if (ireq && dreq) begin
                    state_d = last_d_q ? ST_GNT_I : ST_GNT_D;
                end else if (ireq) begin
                    state_d = ST_GNT_I;
                end else if (dreq) begin
                    state_d = ST_GNT_D;
                end
            end

            ST_GNT_I: begin
                bus.gnt_o  = GNT_I;
                bus.cyc_o  = ireq;
                bus.stb_o  = ireq;
                bus.adr_o  = bus.iadr_i;
                bus.siz_o  = bus.isiz_i;
                bus.iack_o = bus.ack_i;
                bus.idat_o = bus.dat_i[31:0];
                if (bus.ack_i) begin
                    state_d  = ST_IDLE;
                    last_d_d = 1'b0;
                end else if (!ireq) begin
                    state_d  = ST_IDLE;
                end else begin
`ifdef POLARIS_BUS_TIMEOUT_EN
                    tmo_en = 1'b1;
                    if (tmo_expire_c) begin
                        bus.iack_o = 1'b1;
                        bus.idat_o = IDW'(BUS_ERR_DATA);
                        bus.cyc_o  = 1'b0;
                        bus.stb_o  = 1'b0;
                        bus.berr_o = 1'b1;
                        state_d    = ST_IDLE;
                        last_d_d   = 1'b0;
                    end
`endif
                end
            end

            ST_GNT_D: begin
                bus.gnt_o    = GNT_D;
                bus.cyc_o    = bus.dcyc_i;
                bus.stb_o    = bus.dstb_i;
                bus.we_o     = bus.dwe_i;
                bus.adr_o    = bus.dadr_i;
                bus.dat_o    = bus.ddat_i;
                bus.siz_o    = bus.dsiz_i;
                bus.signed_o = bus.dsigned_i;
                bus.dack_o   = bus.ack_i;
                bus.ddat_o   = bus.dat_i;
                if (bus.ack_i) begin
                    state_d  = ST_IDLE;
                    last_d_d = 1'b1;
                end else if (!dreq) begin
                    state_d  = ST_IDLE;
                end else begin
`ifdef POLARIS_BUS_TIMEOUT_EN
                    tmo_en = 1'b1;
                    if (tmo_expire_c) begin
                        bus.dack_o = 1'b1;
                        bus.ddat_o = BUS_ERR_DATA;
                        bus.cyc_o  = 1'b0;
                        bus.stb_o  = 1'b0;
                        bus.berr_o = 1'b1;
                        state_d    = ST_IDLE;
                        last_d_d   = 1'b1;
                    end
`endif
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios plus random traffic vs. a reference model.
module tb_polaris_bus_arbiter;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [63:0] adr;
        logic [63:0] dat;
        logic [1:0]  siz;
        logic        sgn;
        logic        iack;
        logic [31:0] idat;
        logic        dack;
        logic [63:0] ddat;
        logic        berr;
    } out_t;

    logic clk_i = 1'b0;
    logic reset_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the bus, who finished last, cycles spent waiting.
    int   m_owner;    // 0 none, 1 I, 2 D
    bit   m_last_d;
    int   m_wait;

`ifdef POLARIS_BUS_TIMEOUT_EN
    localparam int TMO_MAX = 15;
`endif

    always #5 clk_i = ~clk_i;

    polaris_bus_arbiter_if #(.AW(64)) bus ();

    polaris_bus_arbiter #(
        .AW(64)
`ifdef POLARIS_BUS_TIMEOUT_EN
        , .TMO_W(4)
`endif
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    function automatic bit m_ireq();
        return bus.isiz_i != 2'b00;
    endfunction

    function automatic bit m_dreq();
        return (bus.dcyc_i === 1'b1) && (bus.dstb_i === 1'b1);
    endfunction

    function automatic bit m_expire();
`ifdef POLARIS_BUS_TIMEOUT_EN
        bit req;
        req = (m_owner == 1) ? m_ireq() : m_dreq();
        return (m_owner != 0) && !bus.ack_i && req && (m_wait == TMO_MAX);
`else
        return 1'b0;
`endif
    endfunction

    function automatic out_t model_out();
        out_t e;
        e = '0;
        if (m_owner == 1) begin
            e.gnt  = 2'b01;
            e.cyc  = m_ireq();
            e.stb  = m_ireq();
            e.adr  = bus.iadr_i;
            e.siz  = bus.isiz_i;
            e.iack = bus.ack_i;
            e.idat = bus.dat_i[31:0];
        end else if (m_owner == 2) begin
            e.gnt  = 2'b10;
            e.cyc  = bus.dcyc_i;
            e.stb  = bus.dstb_i;
            e.we   = bus.dwe_i;
            e.adr  = bus.dadr_i;
            e.dat  = bus.ddat_i;
            e.siz  = bus.dsiz_i;
            e.sgn  = bus.dsigned_i;
            e.dack = bus.ack_i;
            e.ddat = bus.dat_i;
        end
        if (m_expire()) begin
            e.cyc  = 1'b0;
            e.stb  = 1'b0;
            e.berr = 1'b1;
            if (m_owner == 1) begin
                e.iack = 1'b1;
                e.idat = 32'hFFFF_FFFF;
            end else begin
                e.dack = 1'b1;
                e.ddat = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end
        return e;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.gnt  = bus.gnt_o;
        o.cyc  = bus.cyc_o;
        o.stb  = bus.stb_o;
        o.we   = bus.we_o;
        o.adr  = bus.adr_o;
        o.dat  = bus.dat_o;
        o.siz  = bus.siz_o;
        o.sgn  = bus.signed_o;
        o.iack = bus.iack_o;
        o.idat = bus.idat_o;
        o.dack = bus.dack_o;
        o.ddat = bus.ddat_o;
        o.berr = bus.berr_o;
        return o;
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    function automatic void model_step();
        bit ex, req;
        ex = m_expire();
        if (m_owner == 0) begin
            m_wait = 0;
            if (m_ireq() && m_dreq()) m_owner = m_last_d ? 1 : 2;
            else if (m_ireq())        m_owner = 1;
            else if (m_dreq())        m_owner = 2;
        end else begin
            req = (m_owner == 1) ? m_ireq() : m_dreq();
            if (bus.ack_i || ex) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0;
            end else if (!req) begin
                m_owner = 0;
            end else begin
                m_wait++;
            end
        end
    endfunction

    task automatic idle_inputs();
        bus.iadr_i    = '0;
        bus.isiz_i    = 2'b00;
        bus.dcyc_i    = 1'b0;
        bus.dstb_i    = 1'b0;
        bus.dwe_i     = 1'b0;
        bus.dadr_i    = '0;
        bus.ddat_i    = '0;
        bus.dsiz_i    = 2'b00;
        bus.dsigned_i = 1'b0;
        bus.ack_i     = 1'b0;
        bus.dat_i     = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk_i); #1;
        reset_ni = 1'b0;
        idle_inputs();
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        m_owner  = 0;
        m_last_d = 1'b0;
        m_wait   = 0;
    endtask

    task automatic test_reset();
        out_t obs, exp, zero;
        zero = '0;
        @(posedge clk_i); #1;
        reset_ni     = 1'b0;
        bus.isiz_i   = 2'b01;
        bus.dcyc_i   = 1'b1;
        bus.dstb_i   = 1'b1;
        bus.ack_i    = 1'b1;
        bus.dat_i    = {$urandom, $urandom};
        repeat (3) begin
            @(negedge clk_i);
            obs = dut_out();
            n_checks++;
            if (obs !== zero) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want %h", obs, zero);
            end
        end
        bus.ack_i = 1'b0;
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        m_owner = 0; m_last_d = 1'b0; m_wait = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_model c=%0d: got %h want %h", c, obs, exp);
            end
            n_checks++;
            if (c == 0 && bus.gnt_o !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_idle_gnt: got %b want 00", bus.gnt_o);
            end else if (c == 1 && (bus.gnt_o !== 2'b10 || bus.cyc_o !== 1'b1)) begin
                n_fail++;
                $display("FAIL first_grant_d: got gnt=%b cyc=%b want gnt=10 cyc=1", bus.gnt_o, bus.cyc_o);
            end
            model_step();
            @(posedge clk_i); #1;
        end
        // Still granted to D: ack passes through, then async reset kills it mid-cycle.
        bus.ack_i = 1'b1;
        #1;
        n_checks++;
        if (bus.dack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_passthrough: got dack=%b want 1", bus.dack_o);
        end
        #1;
        reset_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.cyc_o !== 1'b0 || bus.dack_o !== 1'b0 || bus.gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: got cyc=%b dack=%b gnt=%b want 0 0 00", bus.cyc_o, bus.dack_o, bus.gnt_o);
        end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        idle_inputs();
    endtask

    task automatic test_fetch();
        out_t obs, exp;
        int iack_cnt, dack_cnt;
        iack_cnt = 0; dack_cnt = 0;
        apply_reset();
        bus.iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
        bus.dat_i  = 64'h0000_0000_0000_0013;
        for (int c = 0; c < 7; c++) begin
            bus.isiz_i = (c < 4) ? 2'b10 : 2'b00;
            bus.ack_i  = (c == 3);
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fetch_model c=%0d: got %h want %h", c, obs, exp);
            end
            if (bus.gnt_o === 2'b01) begin
                n_checks++;
                if (bus.adr_o !== 64'hFFFF_FFFF_FFFF_FF00 || bus.we_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got adr=%h we=%b want adr=ffffffffffffff00 we=0", bus.adr_o, bus.we_o);
                end
            end
            if (bus.iack_o === 1'b1) begin
                iack_cnt++;
                n_checks++;
                if (bus.idat_o !== 32'h13) begin
                    n_fail++;
                    $display("FAIL fetch_data: got %h want 00000013", bus.idat_o);
                end
            end
            if (bus.dack_o !== 1'b0) dack_cnt++;
            model_step();
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (iack_cnt != 1) begin
            n_fail++;
            $display("FAIL fetch_ack_once: got %0d ack cycles want 1", iack_cnt);
        end
        n_checks++;
        if (dack_cnt != 0) begin
            n_fail++;
            $display("FAIL fetch_no_dack: got %0d dack cycles want 0", dack_cnt);
        end
    endtask

    task automatic test_write();
        out_t obs, exp;
        int dack_cnt;
        dack_cnt = 0;
        apply_reset();
        bus.dwe_i     = 1'b1;
        bus.dadr_i    = 64'h1000;
        bus.ddat_i    = 64'hDEAD_BEEF;
        bus.dsiz_i    = 2'b11;
        bus.dsigned_i = 1'b0;
        bus.dat_i     = {$urandom, $urandom};
        for (int c = 0; c < 6; c++) begin
            bus.dcyc_i = (c < 3);
            bus.dstb_i = (c < 3);
            bus.ack_i  = (c == 2);
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL write_model c=%0d: got %h want %h", c, obs, exp);
            end
            if (bus.gnt_o === 2'b10) begin
                n_checks++;
                if (bus.we_o !== 1'b1 || bus.dat_o !== 64'hDEAD_BEEF || bus.siz_o !== 2'b11 ||
                    bus.dack_o !== bus.ack_i || bus.adr_o !== 64'h1000) begin
                    n_fail++;
                    $display("FAIL write_bus: got we=%b dat=%h siz=%b dack=%b adr=%h want 1 deadbeef 11 %b 1000",
                             bus.we_o, bus.dat_o, bus.siz_o, bus.dack_o, bus.adr_o, bus.ack_i);
                end
            end
            if (bus.dack_o === 1'b1) dack_cnt++;
            model_step();
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (dack_cnt != 1) begin
            n_fail++;
            $display("FAIL write_ack_once: got %0d want 1", dack_cnt);
        end
    endtask

    task automatic test_contention();
        out_t obs, exp;
        logic [1:0] pat [12];
        pat = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
        apply_reset();
        bus.isiz_i = 2'b11;
        bus.iadr_i = 64'h40;
        bus.dcyc_i = 1'b1;
        bus.dstb_i = 1'b1;
        bus.dadr_i = 64'h2000;
        for (int c = 0; c < 12; c++) begin
            bus.ack_i = (m_owner != 0) && (m_wait >= 1);
            bus.dat_i = {$urandom, $urandom};
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL contention_model c=%0d: got %h want %h", c, obs, exp);
            end
            n_checks++;
            if (bus.gnt_o !== pat[c]) begin
                n_fail++;
                $display("FAIL contention_gnt c=%0d: got %b want %b", c, bus.gnt_o, pat[c]);
            end
            model_step();
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_abort();
        out_t obs, exp;
        bit dreq_seq [8];
        bit ack_seq  [8];
        logic [1:0] pat [8];
        dreq_seq = '{1, 1, 0, 1, 0, 0, 0, 0};
        ack_seq  = '{0, 0, 0, 1, 0, 0, 1, 0};
        pat      = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        apply_reset();
        bus.dat_i = 64'h1234_5678_9ABC_DEF0;
        for (int c = 0; c < 8; c++) begin
            bus.isiz_i = (c < 7) ? 2'b01 : 2'b00;
            bus.dcyc_i = dreq_seq[c];
            bus.dstb_i = dreq_seq[c];
            bus.ack_i  = ack_seq[c];
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort_model c=%0d: got %h want %h", c, obs, exp);
            end
            n_checks++;
            if (bus.gnt_o !== pat[c]) begin
                n_fail++;
                $display("FAIL abort_gnt c=%0d: got %b want %b", c, bus.gnt_o, pat[c]);
            end
            if (c == 2) begin
                n_checks++;
                if (bus.cyc_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_cyc: got %b want 0", bus.cyc_o);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (bus.iack_o !== 1'b0 || bus.dack_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray_ack: got iack=%b dack=%b want 0 0", bus.iack_o, bus.dack_o);
                end
            end
            model_step();
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_random();
        out_t obs, exp;
        bit i_on, d_on;
        i_on = 1'b0; d_on = 1'b0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) i_on = !i_on;
            if ($urandom_range(0, 7) == 0) d_on = !d_on;
            bus.isiz_i    = i_on ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.iadr_i    = {$urandom, $urandom};
            bus.dcyc_i    = d_on;
            bus.dstb_i    = d_on && ($urandom_range(0, 9) != 0);
            bus.dwe_i     = 1'($urandom_range(0, 1));
            bus.dadr_i    = {$urandom, $urandom};
            bus.ddat_i    = {$urandom, $urandom};
            bus.dsiz_i    = 2'($urandom_range(0, 3));
            bus.dsigned_i = 1'($urandom_range(0, 1));
            bus.ack_i     = ($urandom_range(0, 2) == 0);
            bus.dat_i     = {$urandom, $urandom};
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random c=%0d: got %h want %h", c, obs, exp);
            end
            model_step();
            @(posedge clk_i); #1;
        end
        idle_inputs();
    endtask

`ifdef POLARIS_BUS_TIMEOUT_EN
    task automatic test_timeout();
        out_t obs, exp;
        apply_reset();
        bus.isiz_i = 2'b01;
        bus.iadr_i = 64'h80;
        bus.dat_i  = 64'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            obs = dut_out();
            exp = model_out();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL timeout_model c=%0d: got %h want %h", c, obs, exp);
            end
            n_checks++;
            if (bus.berr_o !== (c == 16)) begin
                n_fail++;
                $display("FAIL tmo_berr c=%0d: got %b want %b", c, bus.berr_o, (c == 16));
            end
            if (c == 16) begin
                n_checks++;
                if (bus.iack_o !== 1'b1 || bus.idat_o !== 32'hFFFF_FFFF || bus.cyc_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_ack: got iack=%b idat=%h cyc=%b want 1 ffffffff 0",
                             bus.iack_o, bus.idat_o, bus.cyc_o);
                end
            end
            model_step();
            @(posedge clk_i); #1;
        end
        idle_inputs();
    endtask
`endif

    initial begin
        reset_ni = 1'b0;
        idle_inputs();
        m_owner = 0; m_last_d = 1'b0; m_wait = 0;
        test_reset();
        test_fetch();
        test_write();
        test_contention();
        test_abort();
        test_random();
`ifdef POLARIS_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Shares one 64-bit memory bus between the CPU's instruction-fetch (I) master and data (D) master.
- Sits between the Polaris CPU core and the system interconnect (RAM/ROM/IO decoder).
- Grants one master per transfer, muxes address/data/control, and routes ack and read data back to the granted master.
- Fair when both masters request: grants alternate.

Parameters:
- AW, 64, address width of both masters and the bus.
- TMO_W, 8, width of the timeout counter; only used with BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- iadr_i  in  AW  I-master fetch address.
- isiz_i  in  2  I-master size; a nonzero value is an active fetch request.
- iack_o  out  1  fetch acknowledge.
- idat_o  out  32  fetch data, equal to bus dat_i[31:0].
- dcyc_i  in  1  D-master cycle.
- dstb_i  in  1  D-master strobe.
- dwe_i  in  1  D-master write enable.
- dadr_i  in  AW  D-master address.
- ddat_i  in  64  D-master write data.
- dsiz_i  in  2  D-master transfer size.
- dsigned_i  in  1  D-master sign-extend load.
- dack_o  out  1  data acknowledge.
- ddat_o  out  64  data read data, equal to bus dat_i.
- cyc_o, stb_o, we_o  out  1 each  shared-bus control.
- adr_o  out  AW  shared-bus address.
- dat_o  out  64  shared-bus write data.
- siz_o  out  2  shared-bus size.
- signed_o  out  1  shared-bus sign-extend flag.
- ack_i  in  1  bus acknowledge.
- dat_i  in  64  bus read data.
- gnt_o  out  2  current grant: 01 = I, 10 = D, 00 = none.
- berr_o  out  1  bus-timeout pulse; only with BUS_TIMEOUT_EN, otherwise tied to 0.

Behaviour:
- Requests: ireq = (isiz_i != 0); dreq = dcyc_i & dstb_i.
- FSM states: IDLE, GNT_I, GNT_D. State, a last-grant bit (last), and the timeout counter are the only registers.
- Reset (reset_ni low, asynchronous): state = IDLE, last = I, counter = 0. All outputs 0: gnt_o = 00, cyc_o = stb_o = we_o = 0, adr_o = dat_o = 0, siz_o = 0, iack_o = dack_o = 0, berr_o = 0.
- IDLE transitions:
  - dreq only -> GNT_D.
  - ireq only -> GNT_I.
  - Both -> GNT_I if last = D, else GNT_D.
  - Neither -> stay in IDLE.
  - The requester is sampled in IDLE, so a grant always costs 1 cycle of latency.
- Granted state (GNT_x):
  - Bus outputs driven combinationally from master x.
  - I side: we_o = 0, dat_o = 0, signed_o = 0.
  - cyc_o = stb_o = 1 in GNT_I; in GNT_D they follow dcyc_i/dstb_i.
  - Non-granted master's ack is 0; its data output is don't-care but held at 0.
  - iack_o = ack_i & (state = GNT_I); dack_o = ack_i & (state = GNT_D). Ack is combinational, with zero added latency on the return path.
- On ack_i in GNT_x: next state = IDLE, last = x. A master that keeps requesting after its ack re-arbitrates in IDLE, giving at least one dead cycle between back-to-back transfers.
- Master drops its request while granted (no ack): return to IDLE next cycle and do not update last. This is an aborted cycle; cyc_o falls with the request.
- ack_i while in IDLE: ignored; no ack is forwarded.
- Reset asserted mid-transfer: cyc_o drops immediately and asynchronously; no ack is forwarded.

Optional Feature:
- Macro: POLARIS_BUS_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to GNT_x and increments each granted cycle without ack_i.
  - When it reaches 2^TMO_W−1 without ack_i, the arbiter forces the granted master's ack high for one cycle with read data = all ones (64'hFFFF_FFFF_FFFF_FFFF; idat_o = 32'hFFFF_FFFF).
  - In that same cycle it pulses berr_o = 1, drops cyc_o/stb_o, and goes to IDLE.
  - A genuine ack_i in the terminal cycle takes precedence: normal ack and no berr_o.
- Undefined: no counter; a grant waits indefinitely; berr_o is constant 0.

Decomposition:
- Package polaris_bus_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_GNT_I = 2'd1, ST_GNT_D = 2'd2;
  - grant encodings GNT_NONE, GNT_I, GNT_D;
  - the error fill constant BUS_ERR_DATA.
- One natural sub-module: polaris_bus_timeout, a counter with clear/enable/expire ports. It is instantiated only under the macro.

Test Plan:
- Reset: hold reset_ni = 0 with ireq and dreq active -> all outputs 0, gnt_o = 00. Release -> first grant to D (last = I at reset), cyc_o = 1 one cycle later.
- Single fetch: isiz_i = 2'b10, iadr_i = 64'hFFFF_FFFF_FFFF_FF00, ack_i after 2 cycles with dat_i = 64'h0000_0000_0000_0013:
  - adr_o matches iadr_i, we_o = 0;
  - iack_o = 1 for exactly 1 cycle with idat_o = 32'h13;
  - dack_o stays 0.
- Data write: dcyc_i = dstb_i = dwe_i = 1, dadr_i = 64'h1000, ddat_i = 64'hDEAD_BEEF, dsiz_i = 2'b11 -> we_o = 1, dat_o = 64'hDEAD_BEEF, siz_o = 11, dack_o mirrors ack_i.
- Contention: ireq and dreq held continuously, ack_i returned 1 cycle after each cyc_o -> grants alternate D, I, D, I, with one IDLE cycle between each.
- Abort: grant D, then drop dcyc_i before ack -> IDLE next cycle; a pending ireq is granted afterwards; a stray ack_i in IDLE is not forwarded.
- Timeout (macro on, TMO_W = 4): grant I, never ack -> after 15 cycles iack_o = 1, idat_o = 32'hFFFF_FFFF, berr_o pulses for 1 cycle, state returns to IDLE.
